aes128_enc_ctrl: RTL and testbench
==================================

Name: aes128_enc_ctrl

Overview:
Iterative AES-128 encryption engine controller. It sequences one full round per clock over a 128-bit state register and a rolling round-key register, through initial key whitening, 9 full rounds and a final round without MixColumns. It sits between the block-level valid/ready stream interface and the combinational round primitives (SubBytes, ShiftRows, MixColumns, round-key XOR). Round keys are expanded on the fly; no key schedule RAM.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  plaintext and key offered
in_ready  output  1  controller can accept a block
plaintext  input  128  bit 127 = state byte 0 (FIPS-197 column-major order)
key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext available
out_ready  input  1  downstream accepts ciphertext
ciphertext  output  128  result, same byte order
busy  output  1  high in RUN or DONE

Behaviour:
- One clock. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets everything.
- Reset values: state reg = 0, rk reg = 0, round = 0, rcon = 8'h01, fsm = IDLE, in_ready = 1 (from the first edge after reset), out_valid = 0, busy = 0, ciphertext = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge where in_valid is high: state <= plaintext ^ key; rk <= key; rcon <= 8'h01; round <= 1; go to RUN.
  - Inputs are sampled only at this edge. Later changes on plaintext/key are ignored.
- RUN:
  - in_ready = 0.
  - Combinationally: rk_n = key_step(rk, rcon).
  - If round < NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_n.
  - If round == NR: state <= ShiftRows(SubBytes(state)) ^ rk_n.
  - Every RUN edge: rk <= rk_n; rcon <= xtime(rcon), where 8'h80 -> 8'h1b; round <= round + 1.
  - On the edge that processes round == NR: go to DONE, out_valid <= 1.
- DONE:
  - out_valid = 1; ciphertext = state reg, held stable until the handshake.
  - On an edge where out_ready is high: out_valid <= 0, go to IDLE.
  - A new block is accepted no earlier than the edge after that handshake. No overlap of blocks.
- Latency: accept at edge T, out_valid high after edge T+NR (10 RUN cycles). Best-case throughput is one block per 12 cycles.
- ciphertext is driven from the state reg at all times. It is only meaningful while out_valid = 1.
- out_ready in IDLE or RUN has no effect. in_valid outside IDLE has no effect, and nothing is queued.
- Reset mid-operation (RUN or DONE) abandons the block: all registers return to their reset values and no out_valid pulse is produced.
- key_step(w, rcon): t = SubWord(RotWord(w[31:0])) ^ {rcon, 24'h0}. Then w0' = w[127:96]^t, w1' = w[95:64]^w0', w2' = w[63:32]^w1', w3' = w[31:0]^w2'.
- round is a 4-bit counter; its legal values are 1..NR in RUN and 0 otherwise.

Decomposition:
- Package aes_pkg holds:
  - the S-box constant function/table;
  - xtime;
  - Nb/Nk/Nr constants (4/4/10);
  - the fsm state enum.
- Sub-module aes_key_step: combinational. Inputs rk[127:0] and rcon[7:0]; output rk_next[127:0]. It uses 4 S-box instances for SubWord.
- The round transform reuses the team's existing SubBytes/ShiftRows/MixColumns/round-key-XOR primitives inside this block. The controller itself owns the FSM, round counter, rcon and registers.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid rises exactly 10 cycles after the accept edge, final internal rk = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> ciphertext stable, in_ready = 0, in_valid pulses ignored. Then out_ready = 1 for one edge -> IDLE, and the next block (App. C.1) is accepted on the following edge and is correct.
- Input stability: change plaintext/key every cycle during RUN -> result still equals the App. B ciphertext.
- Reset mid-RUN: rst_n low at round 5 -> next cycle busy = 0, in_ready = 1, out_valid = 0, and no spurious out_valid appears in the following 15 cycles. A subsequent App. B run is correct.
- Back-to-back: in_valid and out_ready held high with 3 queued blocks -> 3 correct ciphertexts spaced 12 cycles apart, one out_valid pulse each.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte-level round primitives.
// State byte i sits at bits [127-8*i -: 8], column-major (row = i%4, column = i/4).
package aes_pkg;

    localparam int NB     = 4;
    localparam int NK     = 4;
    localparam int NR_128 = 10;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 4 * NB; i++) begin
            o[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % NB) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// On-the-fly AES-128 key expansion: derives the next round key from the current one.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [32*NK-1:0] rk,
    input  logic [7:0]       rcon,
    output logic [32*NK-1:0] rk_next
);

    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;

    assign rot_word = {rk[23:0], rk[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub_word[8*i +: 8] = sbox(rot_word[8*i +: 8]);
    end

    assign t  = sub_word ^ {rcon, 24'h0};
    assign w0 = rk[127:96] ^ t;
    assign w1 = rk[95:64]  ^ w0;
    assign w2 = rk[63:32]  ^ w1;
    assign w3 = rk[31:0]   ^ w2;

    assign rk_next = {w0, w1, w2, w3};

endmodule

// File: rtl/aes128_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys rolled forward on the fly.
// Accepts a block in IDLE, runs NR rounds in RUN, holds the result in DONE until taken.
module aes128_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    if (NR != NR_128) begin : g_nr_check
        $error("aes128_enc_ctrl supports only NR = 10 (AES-128)");
    end

    fsm_e         fsm;
    logic [127:0] state;
    logic [127:0] rk;
    logic [127:0] rk_n;
    logic [127:0] sr;
    logic [127:0] state_n;
    logic [7:0]   rcon;
    logic [3:0]   round;

    aes_key_step u_key_step (
        .rk      (rk),
        .rcon    (rcon),
        .rk_next (rk_n)
    );

    // Final round skips MixColumns.
    always_comb begin
        sr      = shift_rows(sub_bytes(state));
        state_n = (round == 4'(NR)) ? (sr ^ rk_n) : (mix_columns(sr) ^ rk_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm   <= FSM_IDLE;
            state <= '0;
            rk    <= '0;
            rcon  <= 8'h01;
            round <= 4'd0;
        end else begin
            case (fsm)
                FSM_IDLE: begin
                    if (in_valid) begin
                        state <= plaintext ^ key;
                        rk    <= key;
                        rcon  <= 8'h01;
                        round <= 4'd1;
                        fsm   <= FSM_RUN;
                    end
                end
                FSM_RUN: begin
                    state <= state_n;
                    rk    <= rk_n;
                    rcon  <= xtime(rcon);
                    if (round == 4'(NR)) begin
                        round <= 4'd0;
                        fsm   <= FSM_DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                FSM_DONE: begin
                    if (out_ready) begin
                        fsm <= FSM_IDLE;
                    end
                end
                default: fsm <= FSM_IDLE;
            endcase
        end
    end

    assign in_ready   = (fsm == FSM_IDLE);
    assign out_valid  = (fsm == FSM_DONE);
    assign busy       = (fsm != FSM_IDLE);
    assign ciphertext = state;

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Bench for aes128_enc_ctrl: byte-array AES reference model with an S-box built from GF(2^8) inversion.
module tb_aes128_enc_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] ciphertext;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_tab [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes128_enc_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_model(input logic [127:0] pt, input logic [127:0] k,
                             output logic [127:0] ct, output logic [127:0] last_rk);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc;
        logic [31:0] tmp;
        logic [7:0]  a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[4 * c + rr] = t[4 * ((c + rr) % 4) + rr];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        ct = '0;
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
        last_rk = {w[40], w[41], w[42], w[43]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge while the controller is idle; returns at the negedge after the accept edge.
    task automatic send(input logic [127:0] p, input logic [127:0] k);
        plaintext = p;
        key       = k;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_out(input bit scramble, output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            if (scramble) begin
                plaintext = rand128();
                key       = rand128();
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [127:0] p, input logic [127:0] k,
                             input logic [127:0] exp_ct, input logic [127:0] exp_rk, input bit scramble);
        int lat;
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        send(p, k);
        wait_out(scramble, lat);
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_ct"}, ciphertext, exp_ct);
        check({tag, "_rk"}, dut.rk, exp_rk);
        handshake();
        check({tag, "_back_idle"}, 128'({busy, out_valid, in_ready}), 128'b001);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct_m, rk_m, p_r, k_r, ct_hold, rk_c;
        logic [127:0] bp [3];
        logic [127:0] bk [3];
        logic [127:0] be [3];
        int lat, spurious, sent, got, last, cyc;

        build_sbox();

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_flags", 128'({busy, out_valid, in_ready}), 128'b001);
        check("rst_ct", ciphertext, 128'd0);
        check("rst_rk", dut.rk, 128'd0);
        check("rst_rcon_round", 128'({dut.rcon, dut.round}), 128'h010);
        rst_n = 1'b1;
        @(negedge clk);

        aes_model(PT_C, KEY_C, ct_m, rk_c);
        run_check("appB", PT_B, KEY_B, CT_B, RK_B, 1'b0);
        run_check("appC1", PT_C, KEY_C, CT_C, rk_c, 1'b0);

        for (int n = 0; n < 4; n++) begin
            p_r = rand128();
            k_r = rand128();
            aes_model(p_r, k_r, ct_m, rk_m);
            run_check("rand", p_r, k_r, ct_m, rk_m, 1'b0);
        end

        run_check("stable_in", PT_B, KEY_B, CT_B, RK_B, 1'b1);

        // Backpressure: result must hold while downstream stalls and new offers are ignored.
        send(PT_B, KEY_B);
        wait_out(1'b0, lat);
        check("bp_latency", 128'(lat), 128'd10);
        ct_hold = CT_B;
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            plaintext = rand128();
            key       = rand128();
            @(negedge clk);
            check("bp_ct", ciphertext, ct_hold);
            check("bp_flags", 128'({busy, out_valid, in_ready}), 128'b110);
        end
        in_valid = 1'b0;
        handshake();
        check("bp_release", 128'({busy, out_valid, in_ready}), 128'b001);
        run_check("bp_next", PT_C, KEY_C, CT_C, rk_c, 1'b0);

        // Reset while round 5 is pending.
        send(PT_B, KEY_B);
        repeat (4) @(negedge clk);
        check("mid_round", 128'(dut.round), 128'd5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_flags", 128'({busy, out_valid, in_ready}), 128'b001);
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("mid_rst_no_ov", 128'(spurious), 128'd0);
        run_check("after_rst", PT_B, KEY_B, CT_B, RK_B, 1'b0);

        // Back-to-back with out_ready held high.
        bp[0] = PT_B;  bk[0] = KEY_B;  be[0] = CT_B;
        bp[1] = PT_C;  bk[1] = KEY_C;  be[1] = CT_C;
        bp[2] = rand128();
        bk[2] = rand128();
        aes_model(bp[2], bk[2], be[2], rk_m);
        sent = 0;
        got  = 0;
        last = 0;
        cyc  = 0;
        out_ready = 1'b1;
        while (got < 3 && cyc < 80) begin
            if (out_valid) begin
                check("b2b_ct", ciphertext, be[got]);
                if (got > 0) check("b2b_spacing", 128'(cyc - last), 128'd12);
                last = cyc;
                got++;
            end
            if (in_ready && sent < 3) begin
                plaintext = bp[sent];
                key       = bk[sent];
                in_valid  = 1'b1;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 128'(got), 128'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
